// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: initiator request/response and backend memory bus signals of mem_arbiter.
interface mem_arbiter_if;
    logic        i_read_req;
    logic [31:0] i_read_addr;
    logic        i_read_ack;
    logic [31:0] i_read_data;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        bus_err;
    modport slave (
        input  i_read_req, i_read_addr, d_req, d_we, d_addr, d_wdata, d_be,
               mem_gnt, mem_rvalid, mem_rdata,
        output i_read_ack, i_read_data, d_ack, d_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be, bus_err
    );
    modport master (
        output i_read_req, i_read_addr, d_req, d_we, d_addr, d_wdata, d_be,
               mem_gnt, mem_rvalid, mem_rdata,
        input  i_read_ack, i_read_data, d_ack, d_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be, bus_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises fetch and data-port requests onto a single-outstanding backend bus.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed data-port priority.
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
    state_t      state, state_nxt;
    logic        sel_d, port_d, lat_we, err;
    logic [31:0] lat_addr, lat_wdata, i_data, d_data, req_addr, rd_val;
    logic [3:0]  lat_be;
    logic [7:0]  cnt;
    logic        any_req, take, timeout, done_rd;
    assign any_req  = bus.i_read_req | bus.d_req;
    assign take     = (state == IDLE) && any_req;
    assign timeout  = cnt == 8'(TIMEOUT - 1);
    assign done_rd  = (state == WAIT) && (bus.mem_rvalid || timeout);
    assign rd_val   = bus.mem_rvalid ? bus.mem_rdata : 32'h0;
    assign req_addr = sel_d ? bus.d_addr : bus.i_read_addr;
`ifdef ARB_ROUND_ROBIN_EN
    logic rr_i;
    // rr_i set means the fetch port wins the next tie
    always_ff @(posedge clk)
        rr_i <= reset ? 1'b0 : take ? sel_d : rr_i;
    assign sel_d = bus.d_req & (~bus.i_read_req | ~rr_i);
`else
    assign sel_d = bus.d_req;
`endif
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = any_req ? ISSUE : IDLE;
            ISSUE:   state_nxt = bus.mem_gnt ? (lat_we ? ACK : WAIT) : ISSUE;
            WAIT:    state_nxt = done_rd ? ACK : WAIT;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            port_d    <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            cnt       <= '0;
            err       <= 1'b0;
            i_data    <= '0;
            d_data    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == WAIT) ? cnt + 8'd1 : 8'd0;
            if (take) begin
                port_d    <= sel_d;
                lat_we    <= sel_d & bus.d_we;
                lat_addr  <= req_addr & ~32'h3;
                lat_wdata <= sel_d ? bus.d_wdata : 32'h0;
                lat_be    <= (sel_d & bus.d_we) ? bus.d_be : 4'hF;
            end
            // rvalid takes precedence over a simultaneous timeout
            if (done_rd) begin
                err <= ~bus.mem_rvalid;
                if (port_d)
                    d_data <= rd_val;
                else
                    i_data <= rd_val;
            end else if (state == ACK) begin
                err <= 1'b0;
            end
        end
    end
    assign bus.mem_req     = state == ISSUE;
    assign bus.mem_we      = lat_we;
    assign bus.mem_addr    = lat_addr;
    assign bus.mem_wdata   = lat_wdata;
    assign bus.mem_be      = lat_be;
    assign bus.i_read_ack  = (state == ACK) && !port_d && bus.i_read_req;
    assign bus.d_ack       = (state == ACK) && port_d && bus.d_req;
    assign bus.bus_err     = (bus.i_read_ack || bus.d_ack) && err;
    assign bus.i_read_data = i_data;
    assign bus.d_rdata     = d_data;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector bench for mem_arbiter built with TIMEOUT=4.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;
    mem_arbiter_if bus();
    mem_arbiter #(.TIMEOUT(4)) dut (.clk(clk), .reset(reset), .bus(bus));
    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          gd;
        int          rd;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        int          exp_ack;
        int          exp_reqc;
        logic [31:0] exp_i;
        logic [31:0] exp_d;
        logic        exp_err;
    } vec_t;
    vec_t        vecs[8];
    int          total = 0, bad = 0;
    logic [31:0] obs_addr, obs_wdata, obs_i, obs_d;
    logic [3:0]  obs_be;
    logic        obs_we, obs_err, stable, wrong_ack, post_ack;
    int          reqc, ack_cyc;
    int          seq[3];
    int          n;
    logic        rdpend;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    // Drives one transaction from an IDLE cycle (cycle 0) and models the backend.
    task automatic run_txn(input vec_t v);
        int   issue_n = 0, wait_n = 0;
        logic waiting = 1'b0;
        logic mine;
        reqc = 0; stable = 1'b1; ack_cyc = -1; wrong_ack = 1'b0; obs_err = 1'b0;
        @(posedge clk); #1;
        if (v.is_d) begin
            bus.d_req = 1'b1; bus.d_we = v.we; bus.d_addr = v.addr;
            bus.d_wdata = v.wdata; bus.d_be = v.be;
        end else begin
            bus.i_read_req = 1'b1; bus.i_read_addr = v.addr;
        end
        bus.mem_rdata = v.rdata;
        for (int cyc = 1; cyc < 40 && ack_cyc < 0; cyc++) begin
            @(posedge clk); #1;
            bus.mem_gnt = bus.mem_req && issue_n >= v.gd;
            if (bus.mem_req) issue_n++;
            bus.mem_rvalid = waiting && wait_n == v.rd;
            if (waiting) wait_n++;
            @(negedge clk);
            if (bus.mem_req) begin
                if (reqc == 0) begin
                    obs_addr = bus.mem_addr; obs_be = bus.mem_be;
                    obs_we = bus.mem_we; obs_wdata = bus.mem_wdata;
                end else if (bus.mem_addr !== obs_addr) begin
                    stable = 1'b0;
                end
                reqc++;
            end
            if (bus.mem_gnt && !v.we) waiting = 1'b1;
            mine = v.is_d ? bus.d_ack : bus.i_read_ack;
            if (v.is_d ? bus.i_read_ack : bus.d_ack) wrong_ack = 1'b1;
            if (mine) begin
                ack_cyc = cyc; obs_i = bus.i_read_data; obs_d = bus.d_rdata; obs_err = bus.bus_err;
            end
        end
        @(posedge clk); #1;
        bus.i_read_req = 1'b0; bus.d_req = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
        @(negedge clk);
        post_ack = bus.i_read_ack | bus.d_ack;
    endtask
    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h100,  32'h0,    4'h0, 0, 0,  32'hA5A5_0001, 32'h100,  4'hF, 3, 1, 32'hA5A5_0001, 32'h0,         1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'h2002, 32'h1234, 4'h3, 0, 0,  32'h0,         32'h2000, 4'h3, 2, 1, 32'hA5A5_0001, 32'h0,         1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'h3007, 32'h0,    4'h0, 0, 2,  32'hDEAD_BEEF, 32'h3004, 4'hF, 5, 1, 32'hA5A5_0001, 32'hDEAD_BEEF, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 32'h400,  32'h0,    4'h0, 0, -1, 32'h9999_9999, 32'h400,  4'hF, 6, 1, 32'h0,         32'hDEAD_BEEF, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 32'h404,  32'h0,    4'h0, 0, 0,  32'h1111_2222, 32'h404,  4'hF, 3, 1, 32'h1111_2222, 32'hDEAD_BEEF, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 32'h500,  32'h0,    4'h0, 3, 0,  32'hCAFE_0005, 32'h500,  4'hF, 6, 4, 32'hCAFE_0005, 32'hDEAD_BEEF, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 32'h608,  32'h0,    4'h0, 0, 3,  32'h7777_8888, 32'h608,  4'hF, 6, 1, 32'hCAFE_0005, 32'h7777_8888, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 32'h601,  32'h55AA, 4'hC, 1, 0,  32'h0,         32'h600,  4'hC, 3, 2, 32'hCAFE_0005, 32'h7777_8888, 1'b0};
        reset = 1'b1;
        bus.i_read_req = 1'b0; bus.i_read_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
        bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs", {bus.mem_req, bus.mem_we, bus.mem_be, bus.i_read_ack, bus.d_ack, bus.bus_err}, 32'h0);
        check("reset_addr", bus.mem_addr | bus.mem_wdata, 32'h0);
        check("reset_data", bus.i_read_data | bus.d_rdata, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            run_txn(vecs[k]);
            check($sformatf("v%0d_addr", k), obs_addr, vecs[k].exp_addr);
            check($sformatf("v%0d_be", k), 32'(obs_be), 32'(vecs[k].exp_be));
            check($sformatf("v%0d_we", k), 32'(obs_we), 32'(vecs[k].we));
            if (vecs[k].we) check($sformatf("v%0d_wdata", k), obs_wdata, vecs[k].wdata);
            check($sformatf("v%0d_ack_cyc", k), 32'(ack_cyc), 32'(vecs[k].exp_ack));
            check($sformatf("v%0d_req_cycles", k), 32'(reqc), 32'(vecs[k].exp_reqc));
            check($sformatf("v%0d_addr_stable", k), 32'(stable), 32'h1);
            check($sformatf("v%0d_i_data", k), obs_i, vecs[k].exp_i);
            check($sformatf("v%0d_d_data", k), obs_d, vecs[k].exp_d);
            check($sformatf("v%0d_bus_err", k), 32'(obs_err), 32'(vecs[k].exp_err));
            check($sformatf("v%0d_other_ack", k), 32'(wrong_ack), 32'h0);
            check($sformatf("v%0d_ack_pulse", k), 32'(post_ack), 32'h0);
        end
        // Contention from a fresh reset: both ports held high throughout.
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h800; bus.d_wdata = 32'h1; bus.d_be = 4'hF;
        bus.i_read_req = 1'b1; bus.i_read_addr = 32'h900; bus.mem_rdata = 32'h99;
        n = 0; rdpend = 1'b0; seq = '{2, 2, 2};
        for (int cyc = 0; cyc < 40 && n < 3; cyc++) begin
            bus.mem_gnt = bus.mem_req; bus.mem_rvalid = rdpend;
            @(negedge clk);
            rdpend = bus.mem_gnt && !bus.mem_we;
            if (bus.d_ack) begin seq[n] = 1; n++; end
            else if (bus.i_read_ack) begin seq[n] = 0; n++; end
            @(posedge clk); #1;
        end
        bus.d_req = 1'b0; bus.i_read_req = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
        check("cont_count", 32'(n), 32'd3);
`ifdef ARB_ROUND_ROBIN_EN
        check("cont_ack0", 32'(seq[0]), 32'd1);
        check("cont_ack1", 32'(seq[1]), 32'd0);
        check("cont_ack2", 32'(seq[2]), 32'd1);
`else
        check("cont_ack0", 32'(seq[0]), 32'd1);
        check("cont_ack1", 32'(seq[1]), 32'd1);
        check("cont_ack2", 32'(seq[2]), 32'd1);
`endif
        // Reset while in WAIT, then a stale rvalid right after reset.
        @(posedge clk); #1;
        bus.i_read_req = 1'b1; bus.i_read_addr = 32'hA00; bus.mem_rdata = 32'hBAD0_BAD0;
        @(posedge clk); #1; bus.mem_gnt = bus.mem_req;
        @(negedge clk);
        check("rst_issue_req", 32'(bus.mem_req), 32'h1);
        @(posedge clk); #1; bus.mem_gnt = 1'b0; reset = 1'b1; bus.i_read_req = 1'b0;
        @(posedge clk); #1; reset = 1'b0; bus.mem_rvalid = 1'b1;
        @(negedge clk);
        check("rst_req_drop", 32'(bus.mem_req), 32'h0);
        check("rst_no_ack0", 32'(bus.i_read_ack | bus.d_ack), 32'h0);
        @(posedge clk); #1; bus.mem_rvalid = 1'b0;
        @(negedge clk);
        check("rst_no_ack1", 32'(bus.i_read_ack | bus.d_ack | bus.bus_err), 32'h0);
        check("rst_i_data", bus.i_read_data, 32'h0);
        check("rst_d_data", bus.d_rdata, 32'h0);
        run_txn('{1'b0, 1'b0, 32'h700, 32'h0, 4'h0, 0, 0, 32'h0BAD_F00D, 32'h700, 4'hF, 3, 1, 32'h0BAD_F00D, 32'h0, 1'b0});
        check("post_rst_ack_cyc", 32'(ack_cyc), 32'd3);
        check("post_rst_i_data", obs_i, 32'h0BAD_F00D);
        check("post_rst_err", 32'(obs_err), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
